hslp_dot_acc: RTL and testbench
===============================

HSLP_DOT_ACC -- requirements
Module: hslp_dot_acc

Interface
REQ-001 Parameter ACC_W, default 24, SHALL set the accumulator/result width in bits (legal range 16..32).
REQ-002 Parameter MAX_LEN, default 256, SHALL set the maximum number of products per frame (legal range 1..1024).
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-005 Port prod_valid, input, 1 bit, SHALL flag a valid product beat from the upstream 8x8 approximate multiplier.
REQ-006 Port prod, input, 16 bits, SHALL carry the unsigned 16-bit product.
REQ-007 Port prod_last, input, 1 bit, SHALL mark the final beat of a frame.
REQ-008 Port prod_ready, output, 1 bit, SHALL indicate that the block accepts a beat this cycle.
REQ-009 Port sum_valid, output, 1 bit, SHALL flag a valid frame result.
REQ-010 Port sum_ready, input, 1 bit, SHALL be downstream acceptance of the result.
REQ-011 Port sum, output, ACC_W bits, SHALL carry the saturated unsigned frame sum.
REQ-012 Port sum_count, output, $clog2(MAX_LEN+1) bits, SHALL carry the number of beats in the frame.
REQ-013 Port sum_ovf, output, 1 bit, SHALL be set if saturation occurred anywhere in the frame.

Function
REQ-014 A beat SHALL be accepted only in a cycle where prod_valid and prod_ready are both 1.
REQ-015 The FSM SHALL have three states: IDLE (no frame open), ACCUM (frame open), and HOLD (result presented).
REQ-016 In IDLE and ACCUM, prod_ready SHALL be 1; in HOLD, prod_ready SHALL be 0.
REQ-017 An accepted beat in IDLE SHALL start a frame: acc <= prod, count <= 1, ovf <= 0.
REQ-018 An accepted beat in ACCUM SHALL add into the frame: acc <= sat(acc + prod), count <= count + 1, ovf <= ovf | carry.
REQ-019 sat() SHALL compute the sum at ACC_W+1 bits and clamp to 2^ACC_W-1 when bit ACC_W is set.
REQ-020 A beat SHALL close its frame when it is accepted with prod_last=1, or when it makes count equal MAX_LEN.
REQ-021 Closing a frame SHALL move the FSM to HOLD and register sum, sum_count, and sum_ovf including the closing beat.
REQ-022 sum_valid SHALL be 1 exactly while in HOLD, i.e. one cycle after the closing beat.
REQ-023 In HOLD, sum, sum_count, and sum_ovf SHALL stay stable until sum_valid and sum_ready are both 1.
REQ-024 On the sum handshake, the FSM SHALL go to IDLE and deassert sum_valid in the next cycle; no beat is accepted in the handshake cycle.
REQ-025 An accepted beat with no close condition SHALL move the FSM from IDLE to ACCUM, or keep it in ACCUM.
REQ-026 A cycle with no accepted beat SHALL leave acc, count, and state unchanged, so idle gaps are allowed mid-frame.
REQ-027 With MAX_LEN=1, every beat SHALL close its own frame.
REQ-028 prod_last in IDLE SHALL produce a one-beat frame.

Reset
REQ-029 When rst_n=0, state SHALL go to IDLE, and acc, count, sum, sum_count, sum_ovf, and sum_valid SHALL all be 0, immediately and regardless of clk.
REQ-030 prod_ready SHALL be 1 from the first cycle after rst_n deasserts.
REQ-031 Reset mid-frame or in HOLD SHALL discard the partial frame or pending result with no output.

Structure
REQ-032 Package hslp_pkg SHALL hold the FSM state enum (IDLE, ACCUM, HOLD) and the default ACC_W/MAX_LEN constants.
REQ-033 The saturating adder SHALL be one sub-module, hslp_sat_add (parameter W; inputs a[W-1:0], b[15:0]; outputs s[W-1:0], ovf); all other logic SHALL be in hslp_dot_acc.

Verification
REQ-034 Beats 0x0010, 0x0020, 0x0030 (last on the third) -> one cycle later: sum_valid=1, sum=0x000060, sum_count=3, sum_ovf=0.
REQ-035 ACC_W=16, beats 0xFFFF then 0x0001 (last) -> sum=0xFFFF, sum_ovf=1, sum_count=2.
REQ-036 MAX_LEN=4, five beats of 0x0100 with no prod_last -> first result sum=0x000400, count=4; the fifth beat is stalled (prod_ready=0) until the sum handshake, then opens a new frame.
REQ-037 sum_ready held 0 for 5 cycles in HOLD -> sum, sum_count, and sum_ovf stable and prod_ready=0 throughout; sum_valid falls the cycle after sum_ready=1.
REQ-038 rst_n pulsed low after 2 of 3 beats -> no sum_valid; the next frame 0x0005 (last) yields sum=0x000005, count=1.
REQ-039 prod_valid toggling 1,0,0,1(last) with 0x0002 each -> sum=0x000004, count=2.

Source files
------------

// File: rtl/hslp_pkg.sv
// Shared types and defaults for the approximate-multiplier dot accumulator.
// Holds the frame FSM encoding and the default parameter values.
package hslp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } hslp_state_t;

  localparam int ACC_W_DEF   = 24;
  localparam int MAX_LEN_DEF = 256;

endpackage

// File: rtl/hslp_sat_add.sv
// Unsigned saturating adder: W-bit accumulator plus 16-bit product.
// Clamps to all-ones when the W+1-bit sum carries out.
module hslp_sat_add #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [15:0]  b,
  output logic [W-1:0] s,
  output logic         ovf
);

  logic [W:0] a_w;
  logic [W:0] b_w;
  logic [W:0] sum_w;

  always_comb begin
    a_w       = '0;
    a_w[W-1:0] = a;
    b_w       = '0;
    b_w[15:0] = b;
    sum_w     = a_w + b_w;
    ovf       = sum_w[W];
    s         = ovf ? '1 : sum_w[W-1:0];
  end

endmodule

// File: rtl/hslp_dot_acc.sv
// Frame accumulator for 16-bit products with saturation and beat count.
// Result is held in HOLD until the downstream handshake completes.
module hslp_dot_acc
  import hslp_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prod_valid,
  input  logic [15:0]      prod,
  input  logic             prod_last,
  output logic             prod_ready,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [ACC_W-1:0] sum,
  output logic [CW-1:0]    sum_count,
  output logic             sum_ovf
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_LEN);

  hslp_state_t      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CW-1:0]    sum_count_q, sum_count_d;
  logic             sum_ovf_q, sum_ovf_d;

  logic [ACC_W-1:0] add_s;
  logic             add_ovf;
  logic [ACC_W-1:0] ext_prod;
  logic [ACC_W-1:0] beat_acc;
  logic [CW-1:0]    beat_cnt;
  logic             beat_ovf;
  logic             fire;
  logic             in_acc;

  hslp_sat_add #(
    .W (ACC_W)
  ) u_add (
    .a   (acc_q),
    .b   (prod),
    .s   (add_s),
    .ovf (add_ovf)
  );

  assign prod_ready = (state_q != HOLD);
  assign sum_valid  = (state_q == HOLD);
  assign sum        = sum_q;
  assign sum_count  = sum_count_q;
  assign sum_ovf    = sum_ovf_q;

  always_comb begin
    ext_prod       = '0;
    ext_prod[15:0] = prod;
    in_acc         = (state_q == ACCUM);
    fire           = prod_valid && prod_ready;
    // A beat in IDLE opens a fresh frame; in ACCUM it folds into the sum.
    beat_acc = in_acc ? add_s : ext_prod;
    beat_cnt = in_acc ? cnt_q + CW'(1) : CW'(1);
    beat_ovf = in_acc ? (ovf_q | add_ovf) : 1'b0;

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    sum_d       = sum_q;
    sum_count_d = sum_count_q;
    sum_ovf_d   = sum_ovf_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (fire) begin
          acc_d = beat_acc;
          cnt_d = beat_cnt;
          ovf_d = beat_ovf;
          if (prod_last || beat_cnt == MAX_C) begin
            state_d     = HOLD;
            sum_d       = beat_acc;
            sum_count_d = beat_cnt;
            sum_ovf_d   = beat_ovf;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (sum_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      sum_q       <= '0;
      sum_count_q <= '0;
      sum_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      sum_q       <= sum_d;
      sum_count_q <= sum_count_d;
      sum_ovf_q   <= sum_ovf_d;
    end
  end

endmodule

// File: tb/tb_hslp_dot_acc.sv
// Directed bench: default, ACC_W=16 and MAX_LEN=4 instances share stimulus.
// Each scenario checks the instance it targets against hand values.
module tb_hslp_dot_acc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pv = 1'b0;
  logic [15:0] pd = '0;
  logic pl = 1'b0;
  logic sr = 1'b0;

  always #5 clk = ~clk;

  logic        r0, v0, o0;
  logic [23:0] s0;
  logic [8:0]  c0;
  logic        r1, v1, o1;
  logic [15:0] s1;
  logic [8:0]  c1;
  logic        r4, v4, o4;
  logic [23:0] s4;
  logic [2:0]  c4;

  int checks = 0;
  int errors = 0;
  int sel = 0;

  hslp_dot_acc u_d0 (
    .clk(clk), .rst_n(rst_n),
    .prod_valid(pv), .prod(pd), .prod_last(pl),
    .prod_ready(r0), .sum_valid(v0), .sum_ready(sr),
    .sum(s0), .sum_count(c0), .sum_ovf(o0)
  );

  hslp_dot_acc #(.ACC_W(16)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .prod_valid(pv), .prod(pd), .prod_last(pl),
    .prod_ready(r1), .sum_valid(v1), .sum_ready(sr),
    .sum(s1), .sum_count(c1), .sum_ovf(o1)
  );

  hslp_dot_acc #(.MAX_LEN(4)) u_d4 (
    .clk(clk), .rst_n(rst_n),
    .prod_valid(pv), .prod(pd), .prod_last(pl),
    .prod_ready(r4), .sum_valid(v4), .sum_ready(sr),
    .sum(s4), .sum_count(c4), .sum_ovf(o4)
  );

  function automatic logic cur_rdy();
    if (sel == 1) return r1;
    if (sel == 2) return r4;
    return r0;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic beat(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    pv = 1'b1;
    pd = d;
    pl = l;
    while (!cur_rdy() && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL beat_timeout got ready=0 want ready=1");
    end
    @(negedge clk);
    pv = 1'b0;
    pl = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    sr = 1'b0;
    pv = 1'b0;
    pl = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic release_sum();
    sr = 1'b1;
    @(negedge clk);
    sr = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({v0, s0, c0, o0} !== '0) begin
      errors++;
      $display("FAIL reset_d0 got v=%0b s=%h c=%0d o=%0b want all 0",
               v0, s0, c0, o0);
    end
    checks++;
    if ({v1, s1, c1, o1} !== '0) begin
      errors++;
      $display("FAIL reset_d1 got v=%0b s=%h c=%0d o=%0b want all 0",
               v1, s1, c1, o1);
    end
    checks++;
    if ({v4, s4, c4, o4} !== '0) begin
      errors++;
      $display("FAIL reset_d4 got v=%0b s=%h c=%0d o=%0b want all 0",
               v4, s4, c4, o4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({r0, r1, r4} !== 3'b111) begin
      errors++;
      $display("FAIL reset_ready got %b want 111", {r0, r1, r4});
    end
  endtask

  task automatic test_basic();
    do_reset();
    sel = 0;
    beat(16'h0010, 1'b0);
    checks++;
    if (v0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_early got sum_valid=%0b want 0", v0);
    end
    beat(16'h0020, 1'b0);
    beat(16'h0030, 1'b1);
    checks++;
    if ({v0, s0, c0, o0} !== {1'b1, 24'h000060, 9'd3, 1'b0}) begin
      errors++;
      $display("FAIL basic got v=%0b s=%h c=%0d o=%0b want 1 000060 3 0",
               v0, s0, c0, o0);
    end
    checks++;
    if (r0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold_ready got %0b want 0", r0);
    end
    release_sum();
    checks++;
    if ({v0, r0} !== 2'b01) begin
      errors++;
      $display("FAIL basic_release got v=%0b r=%0b want v=0 r=1", v0, r0);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    sel = 1;
    beat(16'hFFFF, 1'b0);
    beat(16'h0001, 1'b1);
    checks++;
    if ({v1, s1, c1, o1} !== {1'b1, 16'hFFFF, 9'd2, 1'b1}) begin
      errors++;
      $display("FAIL sat16 got v=%0b s=%h c=%0d o=%0b want 1 ffff 2 1",
               v1, s1, c1, o1);
    end
    checks++;
    if ({v0, s0, c0, o0} !== {1'b1, 24'h010000, 9'd2, 1'b0}) begin
      errors++;
      $display("FAIL nosat24 got v=%0b s=%h c=%0d o=%0b want 1 010000 2 0",
               v0, s0, c0, o0);
    end
    release_sum();
  endtask

  task automatic test_maxlen_hold();
    do_reset();
    sel = 2;
    for (int i = 0; i < 4; i++) beat(16'h0100, 1'b0);
    checks++;
    if ({v4, s4, c4, o4, r4} !== {1'b1, 24'h000400, 3'd4, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL maxlen got v=%0b s=%h c=%0d o=%0b r=%0b want 1 000400 4 0 0",
               v4, s4, c4, o4, r4);
    end
    pv = 1'b1;
    pd = 16'h0100;
    pl = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({v4, s4, c4, o4, r4} !== {1'b1, 24'h000400, 3'd4, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL hold_stable[%0d] got v=%0b s=%h c=%0d o=%0b r=%0b", i,
                 v4, s4, c4, o4, r4);
      end
    end
    sr = 1'b1;
    @(negedge clk);
    sr = 1'b0;
    checks++;
    if ({v4, r4} !== 2'b01) begin
      errors++;
      $display("FAIL hold_release got v=%0b r=%0b want v=0 r=1", v4, r4);
    end
    @(negedge clk);
    pv = 1'b0;
    beat(16'h0001, 1'b1);
    checks++;
    if ({v4, s4, c4, o4} !== {1'b1, 24'h000101, 3'd2, 1'b0}) begin
      errors++;
      $display("FAIL stalled_beat got v=%0b s=%h c=%0d o=%0b want 1 000101 2 0",
               v4, s4, c4, o4);
    end
    release_sum();
  endtask

  task automatic test_reset_mid();
    logic seen;
    do_reset();
    sel = 0;
    beat(16'h0001, 1'b0);
    beat(16'h0002, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({v0, s0, c0, o0} !== '0) begin
      errors++;
      $display("FAIL async_reset got v=%0b s=%h c=%0d o=%0b want all 0",
               v0, s0, c0, o0);
    end
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen = seen | v0;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard got sum_valid=1 want 0");
    end
    beat(16'h0005, 1'b1);
    checks++;
    if ({v0, s0, c0, o0} !== {1'b1, 24'h000005, 9'd1, 1'b0}) begin
      errors++;
      $display("FAIL after_reset got v=%0b s=%h c=%0d o=%0b want 1 000005 1 0",
               v0, s0, c0, o0);
    end
    release_sum();
  endtask

  task automatic test_gaps();
    do_reset();
    sel = 0;
    beat(16'h0002, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (v0 !== 1'b0) begin
      errors++;
      $display("FAIL gap_early got sum_valid=%0b want 0", v0);
    end
    beat(16'h0002, 1'b1);
    checks++;
    if ({v0, s0, c0, o0} !== {1'b1, 24'h000004, 9'd2, 1'b0}) begin
      errors++;
      $display("FAIL gaps got v=%0b s=%h c=%0d o=%0b want 1 000004 2 0",
               v0, s0, c0, o0);
    end
    release_sum();
  endtask

  task automatic test_back_to_back();
    do_reset();
    sel = 0;
    beat(16'h0007, 1'b1);
    release_sum();
    beat(16'h0003, 1'b0);
    beat(16'h0004, 1'b1);
    checks++;
    if ({v0, s0, c0, o0} !== {1'b1, 24'h000007, 9'd2, 1'b0}) begin
      errors++;
      $display("FAIL b2b got v=%0b s=%h c=%0d o=%0b want 1 000007 2 0",
               v0, s0, c0, o0);
    end
    release_sum();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_maxlen_hold();
    test_reset_mid();
    test_gaps();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
